// File: rtl/display_mux_n_pkg.sv
// display_pkg
//   Shared definitions for the multiplexed 7-segment display driver:
//   - state_e        : sequencer states (BLANK between digits, SHOW while lit)
//   - SEG7_PAT       : 16-entry hex-to-segment table, active-high, bit 0 = a .. bit 6 = g
//   - POL_ACTIVE_*   : polarity selectors for pin-level inversion
//   - seg_pol()      : applies a polarity selector to a 7-bit segment vector
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Standard hex glyphs, gfedcba order (b and d are lowercase forms).
  localparam logic [6:0] SEG7_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  localparam bit POL_ACTIVE_HIGH = 1'b0;
  localparam bit POL_ACTIVE_LOW  = 1'b1;

  // Convert an active-high segment vector to pin level.
  function automatic logic [6:0] seg_pol(input logic [6:0] v, input bit pol);
    return (pol == POL_ACTIVE_LOW) ? ~v : v;
  endfunction

endpackage

// File: rtl/display_mux_n_hex_to_seg7.sv
// hex_to_seg7
//   Combinational hex nibble to 7-segment decoder. Output is always
//   active-high; pin polarity is applied by the caller.
//   nibble_i : 4-bit hex digit
//   seg_o    : segments a..g, seg_o[0] = a
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_PAT[nibble_i];

endmodule

// File: rtl/display_mux_n.sv
// display_mux_n
//   Time-multiplexed driver for an N-digit 7-segment display. Each digit is
//   preceded by a BLANK phase (all anodes off) and then lit for a SHOW phase
//   whose anode is PWM-gated by the brightness value. Inputs are captured
//   once per frame so a digit update never tears mid-scan.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   en          : 1 = scan, 0 = freeze sequencer and darken outputs
//   value       : nibble i drives digit i (digit 0 = rightmost)
//   dp          : decimal point per digit
//   lz_en       : leading-zero suppression
//   bright      : PWM duty in sixteenths of the SHOW phase
//   anode       : one-hot digit select, pin polarity per AN_ACTIVE_LOW
//   seg         : segments a..g, pin polarity per SEG_ACTIVE_LOW
//   seg_dp      : decimal-point segment, same polarity as seg
//   frame_start : one-cycle pulse marking a new input snapshot
module display_mux_n
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int BLANK_CYC      = 3000,
  parameter int SHOW_CYC       = 3000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_en,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic                    frame_start
);

  localparam int CNT_MAX = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
  // SHOW_CYC >= 16 guarantees at least 4 counter bits for the PWM compare.
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam bit AN_POL  = (AN_ACTIVE_LOW  != 0) ? POL_ACTIVE_LOW : POL_ACTIVE_HIGH;
  localparam bit SEG_POL = (SEG_ACTIVE_LOW != 0) ? POL_ACTIVE_LOW : POL_ACTIVE_HIGH;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_POL}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_POL}};

  // Sequencer state
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  // Frame snapshot
  logic [4*NUM_DIGITS-1:0] value_snap_q;
  logic [NUM_DIGITS-1:0]   dp_snap_q;
  logic                    lz_snap_q;
  logic [3:0]              bright_snap_q;

  // Registered pins
  logic [NUM_DIGITS-1:0]   anode_q;
  logic [6:0]              seg_q;
  logic                    seg_dp_q;
  logic                    frame_start_q;

  // Per-digit decode helpers
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS:1]     zero_above;
  logic [NUM_DIGITS-1:0]   dark_vec;
  logic [NUM_DIGITS-1:0]   an_act;

  logic [3:0]              cur_nibble;
  logic [6:0]              cur_pat;
  logic                    cur_dark;
  logic                    lit;
  logic                    pwm_on;
  logic                    an_on;
  logic                    take_snap;

  // zero_above[i] is set when digit i and every higher digit are zero;
  // digit 0 is never suppressed so a value of zero still shows "0".
  assign zero_above[NUM_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = value_snap_q[gi*4 +: 4];
    if (gi == 0) begin : g_lsd
      assign dark_vec[gi] = 1'b0;
    end else begin : g_upper
      assign zero_above[gi] = (nib[gi] == 4'd0) && zero_above[gi+1];
      assign dark_vec[gi]   = lz_snap_q && zero_above[gi];
    end
    assign an_act[gi] = an_on && (idx_q == IDX_W'(gi));
  end

  assign cur_nibble = nib[idx_q];
  assign cur_dark   = dark_vec[idx_q];

  hex_to_seg7 u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (cur_pat)
  );

  // Segment data is held constant across the whole SHOW phase; only the
  // anode is PWM-gated, so the lit pattern never changes under an active anode.
  assign lit       = (state_q == SHOW) && !cur_dark;
  assign pwm_on    = cnt_q[3:0] < bright_snap_q;
  assign an_on     = lit && pwm_on;
  assign take_snap = en && (state_q == BLANK) && (cnt_q == '0) && (idx_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      value_snap_q  <= '0;
      dp_snap_q     <= '0;
      lz_snap_q     <= 1'b0;
      bright_snap_q <= 4'd0;
      anode_q       <= AN_OFF;
      seg_q         <= SEG_OFF;
      seg_dp_q      <= SEG_POL;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= take_snap;
      if (en) begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        idx_q    <= idx_d;
        anode_q  <= AN_OFF ^ an_act;
        seg_q    <= seg_pol(lit ? cur_pat : 7'd0, SEG_POL);
        seg_dp_q <= SEG_POL ^ (lit && dp_snap_q[idx_q]);
        if (take_snap) begin
          value_snap_q  <= value;
          dp_snap_q     <= dp;
          lz_snap_q     <= lz_en;
          bright_snap_q <= bright;
        end
      end else begin
        // Frozen: sequencer and snapshot hold, pins go dark.
        anode_q  <= AN_OFF;
        seg_q    <= SEG_OFF;
        seg_dp_q <= SEG_POL;
      end
    end
  end

  assign anode       = anode_q;
  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_mux_n.sv
// tb_display_mux_n
//   Frame-level scoreboard bench for display_mux_n (4 digits, BLANK=2,
//   SHOW=16, both polarities active-low). For every frame the expected
//   per-digit on-time, first lit offset, glyph and dp are queued when the
//   inputs for that frame are driven, and compared when the monitor sees the
//   frame close at the next frame_start.
module tb_display_mux_n;

  localparam int ND    = 4;
  localparam int BC    = 2;
  localparam int SC    = 16;
  localparam int FRAME = ND * (BC + SC);
  localparam int NS    = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [15:0]   value = '0;
  logic [ND-1:0] dp = '0;
  logic          lz_en = 1'b0;
  logic [3:0]    bright = '0;
  logic [ND-1:0] anode;
  logic [6:0]    seg;
  logic          seg_dp;
  logic          frame_start;

  always #5 clk = ~clk;

  display_mux_n #(
    .NUM_DIGITS     (ND),
    .BLANK_CYC      (BC),
    .SHOW_CYC       (SC),
    .AN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .value       (value),
    .dp          (dp),
    .lz_en       (lz_en),
    .bright      (bright),
    .anode       (anode),
    .seg         (seg),
    .seg_dp      (seg_dp),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [15:0]        len;
    logic [ND-1:0][7:0] on;
    logic [ND-1:0][7:0] first;
    logic [ND-1:0][6:0] seg;
    logic [ND-1:0]      dpv;
  } frame_t;

  typedef struct packed {
    logic [15:0]   value;
    logic [ND-1:0] dp;
    logic          lz;
    logic [3:0]    bright;
    logic          drop;
  } step_t;

  int     total = 0;
  int     bad   = 0;
  frame_t sb [$];
  step_t  steps [NS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  // Standard hex glyphs, bit 0 = a .. bit 6 = g, active-high.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  // Expected frame as seen on the pins. Offsets count from the cycle that
  // shows frame_start; digit i's SHOW begins BC cycles into its slot. The en
  // drop happens inside digit 2, so only digit 3 is pushed later.
  function automatic frame_t model(input step_t s);
    frame_t m;
    bit     zero;
    bit     dark;
    logic [3:0] n;
    m = '0;
    m.len = 16'(FRAME + (s.drop ? 10 : 0));
    zero = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      n = s.value[i*4 +: 4];
      zero = zero && (n == 4'd0);
      dark = s.lz && (i != 0) && zero;
      m.on[i]    = dark ? 8'd0 : 8'(s.bright);
      m.first[i] = (m.on[i] == 8'd0) ? 8'hFF
                 : 8'(i * (BC + SC) + BC + ((s.drop && i > 2) ? 10 : 0));
      m.seg[i]   = ~glyph(n);
      m.dpv[i]   = ~s.dp[i];
    end
    return m;
  endfunction

  // Monitor: accumulate one frame window between frame_start pulses.
  frame_t cur;
  bit     win_open = 1'b0;
  int     off = 0;
  bit     multi = 1'b0;
  bit     unstable = 1'b0;
  int     nframe = 0;

  task automatic close_frame();
    frame_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    $display("frame %0d: len=%0d on=%0d/%0d/%0d/%0d (want len=%0d on=%0d/%0d/%0d/%0d)",
             nframe, cur.len, cur.on[3], cur.on[2], cur.on[1], cur.on[0],
             e.len, e.on[3], e.on[2], e.on[1], e.on[0]);
    chk($sformatf("f%0d_len", nframe), 32'(cur.len), 32'(e.len));
    chk($sformatf("f%0d_multi_anode", nframe), 32'(multi), 32'd0);
    chk($sformatf("f%0d_seg_unstable", nframe), 32'(unstable), 32'd0);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("f%0d_d%0d_on", nframe, i), 32'(cur.on[i]), 32'(e.on[i]));
      chk($sformatf("f%0d_d%0d_first", nframe, i), 32'(cur.first[i]), 32'(e.first[i]));
      if (e.on[i] != 8'd0) begin
        chk($sformatf("f%0d_d%0d_seg", nframe, i), 32'(cur.seg[i]), 32'(e.seg[i]));
        chk($sformatf("f%0d_d%0d_dp", nframe, i), 32'(cur.dpv[i]), 32'(e.dpv[i]));
      end
    end
    nframe++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      win_open = 1'b0;
    end else begin
      if (frame_start === 1'b1) begin
        if (win_open) begin
          cur.len = 16'(off + 1);
          close_frame();
        end
        win_open = 1'b1;
        off      = 0;
        multi    = 1'b0;
        unstable = 1'b0;
        cur      = '0;
        for (int i = 0; i < ND; i++) cur.first[i] = 8'hFF;
      end else if (win_open) begin
        off++;
      end
      if (win_open) begin
        int act;
        act = 0;
        for (int i = 0; i < ND; i++) begin
          if (anode[i] === 1'b0) begin
            act++;
            if (cur.on[i] == 8'd0) begin
              cur.first[i] = 8'(off);
              cur.seg[i]   = seg;
              cur.dpv[i]   = seg_dp;
            end else if (seg !== cur.seg[i] || seg_dp !== cur.dpv[i]) begin
              unstable = 1'b1;
            end
            cur.on[i] = cur.on[i] + 8'd1;
          end
        end
        if (act > 1) multi = 1'b1;
      end
    end
  end

  task automatic drive(input step_t s);
    value  = s.value;
    dp     = s.dp;
    lz_en  = s.lz;
    bright = s.bright;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FRAME + 20; k++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("frame_start_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    steps[0]  = '{value:16'h1234, dp:4'b0000, lz:1'b0, bright:4'd15, drop:1'b0};
    steps[1]  = '{value:16'h0050, dp:4'b0000, lz:1'b1, bright:4'd15, drop:1'b0};
    steps[2]  = '{value:16'h0050, dp:4'b0000, lz:1'b0, bright:4'd15, drop:1'b0};
    steps[3]  = '{value:16'h1234, dp:4'b0000, lz:1'b0, bright:4'd4,  drop:1'b0};
    steps[4]  = '{value:16'h5678, dp:4'b0000, lz:1'b0, bright:4'd0,  drop:1'b0};
    steps[5]  = '{value:16'h1111, dp:4'b0000, lz:1'b0, bright:4'd15, drop:1'b0};
    steps[6]  = '{value:16'h2222, dp:4'b0000, lz:1'b0, bright:4'd15, drop:1'b1};
    steps[7]  = '{value:16'hABCD, dp:4'b0100, lz:1'b0, bright:4'd9,  drop:1'b0};
    steps[8]  = '{value:16'h0000, dp:4'b0000, lz:1'b1, bright:4'd7,  drop:1'b0};
    steps[9]  = '{value:16'hF0E0, dp:4'b1111, lz:1'b1, bright:4'd15, drop:1'b0};
    steps[10] = '{value:16'h0008, dp:4'b1010, lz:1'b1, bright:4'd12, drop:1'b0};

    en = 1'b1;
    drive(steps[0]);
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_seg_dp", 32'(seg_dp), 32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd0);

    sb.push_back(model(steps[0]));
    rst = 1'b1;
    @(negedge clk);
    chk("first_frame_start", 32'(frame_start), 32'd1);

    ok = 1'b1;
    for (int j = 1; j <= NS && ok; j++) begin
      // Now at the frame_start of frame j-1: these inputs land in frame j.
      if (j < NS) begin
        drive(steps[j]);
        sb.push_back(model(steps[j]));
      end
      if (steps[j-1].drop) begin
        repeat (43) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_low_anode", 32'(anode), 32'hF);
        chk("en_low_seg", 32'(seg), 32'h7F);
        chk("en_low_seg_dp", 32'(seg_dp), 32'd1);
        repeat (9) @(negedge clk);
        en = 1'b1;
      end
      wait_fs(ok);
    end

    repeat (2) @(negedge clk);
    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_mux_n.md
# display_mux_n

Parametrised time-multiplexed driver for N-digit common-anode or common-cathode 7-segment displays, with decimal points, leading-zero suppression, PWM brightness and an inter-digit blanking phase. It sits between the datapath (BCD/hex value registers) and the board pins. It is the generalised successor of the fixed 4-digit scanner. Frames are snapshotted so a digit update never tears mid-scan.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- BLANK_CYC, 3000, clk cycles all anodes are off before each digit (≥1)
- SHOW_CYC, 3000, clk cycles each digit's SHOW phase lasts (≥16)
- AN_ACTIVE_LOW, 1, 1 = anode driven 0 when on
- SEG_ACTIVE_LOW, 1, 1 = segment/dp driven 0 when lit

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  1 = scanning; 0 = freeze sequencer, outputs dark
- value  in  4*NUM_DIGITS  nibble i = digit i (digit 0 = rightmost)
- dp  in  NUM_DIGITS  decimal point per digit
- lz_en  in  1  leading-zero suppression enable
- bright  in  4  brightness, duty = bright/16 of SHOW phase
- anode  out  NUM_DIGITS  one-hot digit select (polarity per AN_ACTIVE_LOW)
- seg  out  7  segments, seg[0]=a … seg[6]=g
- seg_dp  out  1  decimal-point segment
- frame_start  out  1  1-cycle pulse when a new snapshot is taken

## Operation
- Sequencer FSM: BLANK → SHOW → BLANK (next digit). Cycle counter cnt counts 0..BLANK_CYC-1 in BLANK and 0..SHOW_CYC-1 in SHOW; it clears on every state change.
- Digit index idx advances on SHOW→BLANK and wraps NUM_DIGITS-1 → 0.
- Snapshot: value, dp, lz_en and bright are latched on the first cycle of BLANK with idx = 0, and frame_start pulses on that same cycle. This includes the first cycle after reset release. Mid-frame input changes have no effect until the next frame.
- Leading-zero suppression (snapshot lz_en = 1): digit i is dark if it and every higher digit are 0 and i ≠ 0. Digit 0 is always shown. A dark digit keeps its anode inactive for the full SHOW phase; its dp is also dark.
- PWM: during SHOW, the anode for idx is active iff (cnt mod 16) < bright_snap. bright_snap = 0 gives always off; 15 gives 15/16 duty.
- Decode: hex 0–F uses standard patterns (active-high a..g: 0=0111111, 1=0000110, 8=1111111, A=1110111, F=1110001). Outputs are inverted when SEG_ACTIVE_LOW = 1.
- en = 0: cnt, idx, FSM and snapshot hold; all outputs go inactive on the next edge. Scanning resumes from the same position on en = 1.
- During BLANK, every anode is inactive and seg/seg_dp are all-off.

## Timing
- Reset (async assert): state = BLANK, cnt = 0, idx = 0, snapshot = 0. anode = all inactive (all 1s when AN_ACTIVE_LOW = 1), seg/seg_dp = off (all 1s when SEG_ACTIVE_LOW = 1), frame_start = 0.
- All outputs are registered: they reflect the FSM/cnt state of the previous cycle, giving 1-cycle latency. There are no combinational paths from inputs to outputs.
- seg/seg_dp change only in BLANK, so segments are stable for the whole period an anode is active (no ghosting).
- Frame period is NUM_DIGITS × (BLANK_CYC + SHOW_CYC) cycles.
- Reset deasserted mid-frame restarts from digit 0, BLANK, cnt = 0.
- If en falls on the same cycle as a state transition, the transition does not occur; it completes after en returns.

## Structure
- Package display_pkg holds:
  - the seg7 pattern constant array (16 × 7, active-high)
  - the state enum typedef {BLANK, SHOW}
  - the polarity helper constants
- Sub-module hex_to_seg7: combinational nibble → 7-bit active-high pattern. Polarity inversion is done in the top level.

## Test plan
Test configuration: NUM_DIGITS = 4, BLANK_CYC = 2, SHOW_CYC = 16, active-low both.
- Reset with value = 16'h1234, bright = 15 → anode = 1111 and seg = 1111111 during reset. After release, frame_start pulses at cycle 1. Digit 0 anode = 1110 with seg = active-low "4" for 15 of 16 SHOW cycles. Digits then scan 1,2,3,0 with 2 dark cycles between each.
- value = 16'h0050, lz_en = 1 → digit 3 and digit 2 anodes never active; digits 1 (5) and 0 (0) shown. With lz_en = 0, digit 3 and digit 2 show "0".
- bright = 4 → each digit's anode is active for exactly 4 of 16 SHOW cycles. bright = 0 → anode stays 1111 for the whole frame.
- Change value from 16'h1111 to 16'h2222 mid-frame → the remainder of the frame shows "1". From the next frame_start onward, all digits show "2".
- Drop en for 10 cycles during digit 2 SHOW → outputs go dark next cycle. After en returns, digit 2 SHOW resumes with the remaining cnt, and the frame length grows by exactly 10 cycles.
- dp = 4'b0100, value = 16'hABCD → seg_dp = 0 only while the digit 2 anode is active; segment patterns match A/B/C/D.
